// File: rtl/sprite_draw_sequencer_if.sv
// sprite_draw_sequencer_if: frame handshake, drawer start/done and pixel buses between
// the draw sequencer (master) and the clearer, sprite drawers and VGA adapter (slave).
interface sprite_draw_sequencer_if #(
   parameter int NUM_SPRITES = 4
);
   logic                        frame_tick;
   logic [NUM_SPRITES-1:0]      enable;
   logic                        clear_start;
   logic                        clear_done;
   logic [9:0]                  clr_x;
   logic [9:0]                  clr_y;
   logic                        clr_we;
   logic [2:0]                  clr_color;
   logic [NUM_SPRITES-1:0]      plot;
   logic [NUM_SPRITES-1:0]      draw_done;
   logic [NUM_SPRITES*10-1:0]   x_bus;
   logic [NUM_SPRITES*10-1:0]   y_bus;
   logic [NUM_SPRITES-1:0]      we_bus;
   logic [NUM_SPRITES*3-1:0]    color_bus;
   logic [9:0]                  vga_x;
   logic [9:0]                  vga_y;
   logic                        vga_we;
   logic [2:0]                  vga_color;
   logic                        busy;
   logic                        frame_done;
   logic                        frame_overrun;
   logic                        timeout_err;
   logic [4:0]                  err_idx;
   logic                        err_clear;
   modport master (
      input  frame_tick, enable, clear_done, clr_x, clr_y, clr_we, clr_color,
             draw_done, x_bus, y_bus, we_bus, color_bus, err_clear,
      output clear_start, plot, vga_x, vga_y, vga_we, vga_color,
             busy, frame_done, frame_overrun, timeout_err, err_idx
   );
   modport slave (
      output frame_tick, enable, clear_done, clr_x, clr_y, clr_we, clr_color,
             draw_done, x_bus, y_bus, we_bus, color_bus, err_clear,
      input  clear_start, plot, vga_x, vga_y, vga_we, vga_color,
             busy, frame_done, frame_overrun, timeout_err, err_idx
   );
endinterface

// File: rtl/sprite_draw_sequencer.sv
// sprite_draw_sequencer: per-frame background clear then in-order sprite plotting,
// with a registered pixel mux onto the VGA write port and a per-stage watchdog.
module sprite_draw_sequencer #(
   parameter int NUM_SPRITES = 4,
   parameter int TIMEOUT     = 4095
) (
   input logic                     clk,
   input logic                     reset_n,
   sprite_draw_sequencer_if.master bus
);
   localparam int          IW           = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
   localparam logic [11:0] TO           = 12'(TIMEOUT);
   localparam logic [2:0]  S_IDLE       = 3'd0;
   localparam logic [2:0]  S_CLEAR      = 3'd1;
   localparam logic [2:0]  S_CLEAR_WAIT = 3'd2;
   localparam logic [2:0]  S_PLOT       = 3'd3;
   localparam logic [2:0]  S_WAIT       = 3'd4;
   localparam logic [2:0]  S_DONE       = 3'd5;

   logic [2:0]             state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d, nxt;
   logic [NUM_SPRITES-1:0] en_q, en_d, pend_q, pend_d, one_hot, avail;
   logic [11:0]            cnt_q, cnt_d;
   logic                   ovr_q, ovr_d, terr_q, terr_d;
   logic [4:0]             eidx_q, eidx_d;
   logic [9:0]             vx_q, vx_d, vy_q, vy_d;
   logic                   vwe_q, vwe_d;
   logic [2:0]             vc_q, vc_d;
   logic                   start, waiting, stage_done, expire, advance, found;

   always_comb begin
      start      = state_q == S_IDLE && bus.frame_tick;
      waiting    = state_q == S_CLEAR_WAIT || state_q == S_WAIT;
      one_hot    = NUM_SPRITES'(1) << idx_q;
      stage_done = state_q == S_CLEAR_WAIT ? bus.clear_done : state_q == S_WAIT && bus.draw_done[idx_q];
      expire     = waiting && !stage_done && cnt_q == TO;
      advance    = stage_done || expire;
      en_d       = start ? bus.enable : en_q;
      pend_d     = start ? '0 : state_q == S_WAIT && advance ? pend_q | one_hot : pend_q;
      avail      = en_q & ~pend_d;
      found      = 1'b0;
      nxt        = '0;
      // descending scan leaves the lowest pending enabled slot selected
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         found = avail[i] ? 1'b1 : found;
         nxt   = avail[i] ? IW'(i) : nxt;
      end
      state_d = state_q == S_IDLE  ? (bus.frame_tick ? S_CLEAR : S_IDLE)
              : state_q == S_CLEAR ? S_CLEAR_WAIT
              : state_q == S_PLOT  ? S_WAIT
              : waiting            ? (advance ? (found ? S_PLOT : S_DONE) : state_q)
              : S_IDLE;
      idx_d   = waiting && advance && found ? nxt : idx_q;
      cnt_d   = state_d == S_CLEAR || state_d == S_PLOT ? 12'd0 : cnt_q == TO ? cnt_q : cnt_q + 12'd1;
      ovr_d   = state_q != S_IDLE && bus.frame_tick ? 1'b1 : bus.err_clear ? 1'b0 : ovr_q;
      terr_d  = expire ? 1'b1 : bus.err_clear ? 1'b0 : terr_q;
      eidx_d  = expire ? (state_q == S_CLEAR_WAIT ? 5'd31 : 5'(idx_q)) : bus.err_clear ? 5'd0 : eidx_q;
      vwe_d   = state_q == S_CLEAR_WAIT ? bus.clr_we : state_q == S_WAIT && bus.we_bus[idx_q];
      vx_d    = state_q == S_CLEAR_WAIT ? bus.clr_x : state_q == S_WAIT ? bus.x_bus[idx_q*10 +: 10] : vx_q;
      vy_d    = state_q == S_CLEAR_WAIT ? bus.clr_y : state_q == S_WAIT ? bus.y_bus[idx_q*10 +: 10] : vy_q;
      vc_d    = state_q == S_CLEAR_WAIT ? bus.clr_color : state_q == S_WAIT ? bus.color_bus[idx_q*3 +: 3] : vc_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         en_q    <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
         terr_q  <= 1'b0;
         eidx_q  <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         vwe_q   <= 1'b0;
         vc_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         en_q    <= en_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         terr_q  <= terr_d;
         eidx_q  <= eidx_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         vwe_q   <= vwe_d;
         vc_q    <= vc_d;
      end
   end

   assign bus.plot          = state_q == S_PLOT ? one_hot : '0;
   assign bus.clear_start   = state_q == S_CLEAR;
   assign bus.busy          = state_q != S_IDLE;
   assign bus.frame_done    = state_q == S_DONE;
   assign bus.frame_overrun = ovr_q;
   assign bus.timeout_err   = terr_q;
   assign bus.err_idx       = eidx_q;
   assign bus.vga_x         = vx_q;
   assign bus.vga_y         = vy_q;
   assign bus.vga_we        = vwe_q;
   assign bus.vga_color     = vc_q;
endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// tb_sprite_draw_sequencer: frames with randomized timing, noise and pixels, checked every
// cycle against a schedule computed from the frame rules (clear, then enabled slots in order).
module tb_sprite_draw_sequencer;
   localparam int N  = 4;
   localparam int TO = 64;

   logic clk      = 1'b0;
   logic reset_n  = 1'b0;
   logic fix_pix1 = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic       m_ovr, m_terr, m_we;
   logic [4:0] m_idx;
   logic [9:0] m_x, m_y;
   logic [2:0] m_c;
   logic [N+10:0] got_c;
   logic [23:0]   got_p;

   sprite_draw_sequencer_if #(.NUM_SPRITES(N)) bus ();
   sprite_draw_sequencer #(.NUM_SPRITES(N), .TIMEOUT(TO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;
   assign got_c = {bus.plot, bus.clear_start, bus.frame_done, bus.busy, bus.frame_overrun, bus.timeout_err, bus.err_idx};
   assign got_p = {bus.vga_x, bus.vga_y, bus.vga_we, bus.vga_color};

   task automatic model_reset;
      {m_ovr, m_terr, m_we, m_idx, m_x, m_y, m_c} = '0;
   endtask

   // Runs one frame from an idle negedge. dc/dd: cycles from clear_start/plot to done (>TO = hang).
   // ovr_at: extra tick cycle (-1 none, -2 at DONE, -3 inside WAIT(1)); abort_at: async reset cycle.
   task automatic run_frame(input logic [N-1:0] en, input int dc, input int dd[N],
                            input int ovr_at, input int clr_pct, input int abort_at);
      int e, t, fd, ot, src;
      int p[N], de[N];
      logic [N-1:0] xp;
      logic [N+10:0] exp_c;
      logic set_t;
      logic [4:0] sidx;
      e = 1 + (dc > TO ? TO : dc);
      t = e;
      for (int i = 0; i < N; i++) begin
         p[i] = -10;
         de[i] = -10;
         if (en[i]) begin
            p[i] = t + 1;
            de[i] = p[i] + (dd[i] > TO ? TO : dd[i]);
            t = de[i];
         end
      end
      fd = t + 1;
      ot = ovr_at == -2 ? fd : ovr_at == -3 ? p[1] + 2 : ovr_at;
      ot = ot > fd ? fd : ot;
      for (int n = 0; n <= fd + 1; n++) begin
         xp = '0;
         for (int i = 0; i < N; i++) xp[i] = en[i] && n == p[i];
         exp_c = {xp, n == 1, n == fd, n >= 1 && n <= fd, m_ovr, m_terr, m_idx};
         n_checks++;
         if (got_c !== exp_c) begin
            n_fail++;
            $display("FAIL ctrl cyc %0d: got %h want %h (plot,clr_start,fdone,busy,ovr,terr,idx)", n, got_c, exp_c);
         end
         n_checks++;
         if (got_p !== {m_x, m_y, m_we, m_c}) begin
            n_fail++;
            $display("FAIL pixel cyc %0d: got %h want %h", n, got_p, {m_x, m_y, m_we, m_c});
         end
         bus.frame_tick = n == 0 || n == ot;
         bus.enable     = n == 0 ? en : N'($urandom);
         bus.err_clear  = $urandom_range(99) < clr_pct;
         bus.clear_done = n == 1 + dc || ($urandom_range(3) == 0 && !(n >= 2 && n <= e));
         bus.clr_x      = 10'($urandom);
         bus.clr_y      = 10'($urandom);
         bus.clr_we     = 1'($urandom);
         bus.clr_color  = 3'($urandom);
         for (int j = 0; j < N; j++) begin
            bus.draw_done[j] = (en[j] && n == p[j] + dd[j]) ||
                               ($urandom_range(3) == 0 && !(en[j] && n > p[j] && n <= de[j]));
            bus.x_bus[j*10 +: 10] = 10'($urandom);
            bus.y_bus[j*10 +: 10] = 10'($urandom);
            bus.we_bus[j]         = 1'($urandom);
            bus.color_bus[j*3 +: 3] = 3'($urandom);
         end
         if (fix_pix1) {bus.x_bus[19:10], bus.y_bus[19:10], bus.we_bus[1], bus.color_bus[5:3]} = {10'd100, 10'd50, 1'b1, 3'b110};
         if (n == abort_at) begin
            #2 reset_n = 1'b0;
            #1 n_checks++;
            if ({got_c, got_p} !== '0) begin
               n_fail++;
               $display("FAIL reset_async: got %h/%h want 0", got_c, got_p);
            end
            model_reset();
            bus.frame_tick = 1'b0;
            repeat (2) @(negedge clk);
            n_checks++;
            if ({got_c, got_p} !== '0) begin
               n_fail++;
               $display("FAIL reset_hold: got %h/%h want 0", got_c, got_p);
            end
            reset_n = 1'b1;
            return;
         end
         src = -1;
         if (n >= 2 && n <= e) src = N;
         for (int i = 0; i < N; i++) if (en[i] && n > p[i] && n <= de[i]) src = i;
         if (src == N) {m_x, m_y, m_we, m_c} = {bus.clr_x, bus.clr_y, bus.clr_we, bus.clr_color};
         else if (src >= 0) {m_x, m_y, m_we, m_c} = {bus.x_bus[src*10 +: 10], bus.y_bus[src*10 +: 10], bus.we_bus[src], bus.color_bus[src*3 +: 3]};
         else m_we = 1'b0;
         set_t = dc > TO && n == e;
         sidx  = 5'd31;
         for (int i = 0; i < N; i++) if (en[i] && dd[i] > TO && n == de[i]) {set_t, sidx} = {1'b1, 5'(i)};
         m_ovr  = bus.frame_tick && n >= 1 && n <= fd ? 1'b1 : bus.err_clear ? 1'b0 : m_ovr;
         m_terr = set_t ? 1'b1 : bus.err_clear ? 1'b0 : m_terr;
         m_idx  = set_t ? sidx : bus.err_clear ? 5'd0 : m_idx;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      {bus.frame_tick, bus.enable, bus.clear_done, bus.clr_x, bus.clr_y, bus.clr_we, bus.clr_color} = '0;
      {bus.draw_done, bus.x_bus, bus.y_bus, bus.we_bus, bus.color_bus, bus.err_clear} = '0;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({got_c, got_p} !== '0) begin
         n_fail++;
         $display("FAIL reset: got %h/%h want 0", got_c, got_p);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({got_c, got_p} !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: got %h/%h want 0", got_c, got_p);
      end
   endtask

   task automatic test_basic_frame;
      int dd[N] = '{20, 20, 20, 20};
      run_frame(4'b1011, 10, dd, -1, 0, -1);
   endtask

   task automatic test_pixel_mux;
      int dd[N] = '{1, 6, 1, 1};
      fix_pix1 = 1'b1;
      run_frame(4'b0010, 4, dd, -1, 0, -1);
      fix_pix1 = 1'b0;
   endtask

   task automatic test_watchdog;
      int dd[N] = '{1000, 10, 1, 1};
      run_frame(4'b0011, 5, dd, -1, 0, -1);
      n_checks++;
      if ({bus.timeout_err, bus.err_idx} !== 6'b1_00000) begin
         n_fail++;
         $display("FAIL wdog_flags: got %b want 100000", {bus.timeout_err, bus.err_idx});
      end
      bus.err_clear = 1'b1;
      @(negedge clk);
      bus.err_clear = 1'b0;
      {m_ovr, m_terr, m_idx} = '0;
      n_checks++;
      if ({bus.frame_overrun, bus.timeout_err, bus.err_idx} !== 7'd0) begin
         n_fail++;
         $display("FAIL wdog_err_clear: got %b want 0", {bus.frame_overrun, bus.timeout_err, bus.err_idx});
      end
   endtask

   task automatic test_overrun;
      int dd[N] = '{3, 8, 1, 1};
      run_frame(4'b0011, 2, dd, -3, 0, -1);
      run_frame(4'b0011, 2, dd, -2, 0, -1);
      n_checks++;
      if (bus.frame_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_sticky: got %b want 1", bus.frame_overrun);
      end
      bus.err_clear = 1'b1;
      @(negedge clk);
      bus.err_clear = 1'b0;
      {m_ovr, m_terr, m_idx} = '0;
      n_checks++;
      if (bus.frame_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear: got %b want 0", bus.frame_overrun);
      end
   endtask

   task automatic test_empty_frame;
      int dd[N] = '{1, 1, 1, 1};
      run_frame(4'b0000, 3, dd, -1, 0, -1);
      run_frame(4'b0000, 1, dd, -1, 0, -1);
   endtask

   task automatic test_mid_reset;
      int dd[N] = '{3, 3, 3, 3};
      run_frame(4'b0111, 1, dd, 5, 0, 13);
      run_frame(4'b0101, 2, dd, -1, 0, -1);
   endtask

   task automatic test_random;
      int dd[N];
      for (int f = 0; f < 16; f++) begin
         for (int i = 0; i < N; i++) dd[i] = $urandom_range(9) == 0 ? 200 : $urandom_range(30, 1);
         run_frame(N'($urandom), $urandom_range(9) == 0 ? 100 : $urandom_range(20, 1), dd,
                   $urandom_range(3) == 0 ? -2 : $urandom_range(1) == 0 ? -1 : $urandom_range(40, 1), 5, -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_pixel_mux();
      test_watchdog();
      test_overrun();
      test_empty_frame();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
